alu_prog_seq: RTL

- Program sequencer for the ALU datapath. After a start pulse it fetches instruction words from the program ROM and reads operands from data RAMs A and B at the decoded addresses.
- It drives the ALU operation code and writes the ALU result into RAM C.
- Sits between the reset/clock generation and the ROM/RAM/ALU instances. It replaces free-running control with a start/busy/done handshake, an abort, and an instruction counter.

---
 rtl/alu_prog_pkg.sv | 26 ++
 rtl/alu_prog_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/alu_prog_pkg.sv
// Shared types and instruction-field layout for the ALU program sequencer.
package alu_prog_pkg;

  localparam int OP_LSB   = 0;
  localparam int OP_MSB   = 7;
  localparam int A_LSB    = 8;
  localparam int B_LSB    = 13;
  localparam int C_LSB    = 18;
  localparam int HALT_BIT = 31;

  localparam logic [7:0] OP_NOP = 8'h00;

  typedef enum logic [2:0] {
    IDLE, FETCH, ROM_WAIT, READ, MEM_WAIT, EXEC, WRITE
  } state_t;

  typedef struct packed {
    logic       halt;
    logic [7:0] rsvd;
    logic [4:0] addr_c;
    logic [4:0] addr_b;
    logic [4:0] addr_a;
    logic [7:0] op;
  } instr_t;

endpackage

// File: rtl/alu_prog_seq.sv
// Program sequencer: fetches ROM instructions, strobes RAM A/B reads, drives
// the ALU op and writes RAM C; start/busy/done handshake with abort.
module alu_prog_seq
  import alu_prog_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int OP_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [ADDR_W:0]    instr_cnt,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_rd,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               mem_a_rd,
  output logic [ADDR_W-1:0]  mem_a_addr,
  output logic               mem_b_rd,
  output logic [ADDR_W-1:0]  mem_b_addr,
  output logic               mem_c_wr,
  output logic [ADDR_W-1:0]  mem_c_addr,
  output logic [OP_W-1:0]    ops
);

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  ir_c;
  logic               ir_halt;
  logic               last;
  logic               rsvd_unused;

  assign rsvd_unused = ^rom_data[HALT_BIT-1:C_LSB+ADDR_W];
  assign last        = ir_halt || (pc == PC_LAST);
  assign rom_addr    = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:     if (start && !abort) state_nxt = FETCH;
        FETCH:    state_nxt = ROM_WAIT;
        ROM_WAIT: state_nxt = READ;
        READ:     state_nxt = MEM_WAIT;
        MEM_WAIT: state_nxt = EXEC;
        EXEC:     state_nxt = WRITE;
        WRITE:    state_nxt = last ? IDLE : FETCH;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so each strobe is visible
  // during the state it belongs to; an abort on the edge into WRITE kills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      rom_rd     <= 1'b0;
      mem_a_rd   <= 1'b0;
      mem_b_rd   <= 1'b0;
      mem_c_wr   <= 1'b0;
      instr_cnt  <= '0;
      pc         <= '0;
      mem_a_addr <= '0;
      mem_b_addr <= '0;
      mem_c_addr <= '0;
      ops        <= '0;
      ir_c       <= '0;
      ir_halt    <= 1'b0;
    end else begin
      busy     <= state_nxt != IDLE;
      rom_rd   <= state_nxt == FETCH;
      mem_a_rd <= state_nxt == READ;
      mem_b_rd <= state_nxt == READ;
      mem_c_wr <= (state_nxt == WRITE) && (ops != OP_W'(OP_NOP));
      done     <= (state_nxt == WRITE) && last;
      aborted  <= (state != IDLE) && abort;
      if (state == IDLE && state_nxt == FETCH) begin
        pc        <= '0;
        instr_cnt <= '0;
      end else if (state == WRITE && state_nxt == FETCH) begin
        pc <= pc + 1'b1;
      end
      if (state_nxt == WRITE) begin
        instr_cnt  <= instr_cnt + 1'b1;
        mem_c_addr <= ir_c;
      end
      // ROM word is valid in ROM_WAIT; decode straight into the READ outputs.
      if (state_nxt == READ) begin
        ops        <= rom_data[OP_LSB +: OP_W];
        mem_a_addr <= rom_data[A_LSB +: ADDR_W];
        mem_b_addr <= rom_data[B_LSB +: ADDR_W];
        ir_c       <= rom_data[C_LSB +: ADDR_W];
        ir_halt    <= rom_data[HALT_BIT];
      end
    end
  end

endmodule
